// File: rtl/pd_header_assembler.sv
// Block-header assembler between the receive front end and the SHA-256d engine.
// Packs BEAT_BYTES-wide beats into an HDR_BYTES header, checks length, and runs the hash handshake.
module pd_header_assembler #(
  parameter int BEAT_BYTES = 1,
  parameter int HDR_BYTES  = 80,
  localparam int CNT_W     = $clog2(HDR_BYTES + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    write_enable,
  input  logic [8*BEAT_BYTES-1:0] rx_data,
  input  logic                    rx_last,
  output logic                    rx_ready,
  output logic [CNT_W-1:0]        byte_cnt,
  output logic [8*HDR_BYTES-1:0]  header,
  output logic [31:0]             target_bits,
  output logic                    header_valid,
  input  logic                    header_ready,
  input  logic                    hash_done,
  input  logic                    valid_hash,
  output logic                    result_valid,
  output logic                    result_found,
  output logic                    len_err,
  output logic                    drop_err
);

  // Handshakes: a beat transfers on a rising edge where write_enable && rx_ready;
  // the header transfers on a rising edge where header_valid && header_ready.
  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_DRAIN,
    S_HOLD,
    S_HASH
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;
  logic             wr_en;
  logic             len_err_next;
  logic             result_valid_next;
  logic             found_next;
  logic             rx_ready_next;
  logic             header_valid_next;
  logic             drop_err_next;

  assign accept  = write_enable & rx_ready;
  assign cnt_inc = byte_cnt + CNT_W'(BEAT_BYTES);

  always_comb begin
    state_next        = state;
    cnt_next          = byte_cnt;
    wr_en             = 1'b0;
    len_err_next      = 1'b0;
    result_valid_next = 1'b0;
    found_next        = result_found;
    case (state)
      S_IDLE, S_FILL: begin
        if (accept) begin
          wr_en    = 1'b1;
          cnt_next = cnt_inc;
          if (rx_last) begin
            if (cnt_inc == CNT_W'(HDR_BYTES)) begin
              state_next = S_HOLD;
            end else begin
              len_err_next = 1'b1;
              state_next   = S_IDLE;
              cnt_next     = '0;
            end
          end else if (cnt_inc == CNT_W'(HDR_BYTES)) begin
            state_next = S_DRAIN;
          end else begin
            state_next = S_FILL;
          end
        end
      end
      S_DRAIN: begin
        // Overlong packet: swallow beats without counting until the last one.
        if (accept && rx_last) begin
          len_err_next = 1'b1;
          state_next   = S_IDLE;
          cnt_next     = '0;
        end
      end
      S_HOLD: begin
        if (header_ready) state_next = S_HASH;
      end
      S_HASH: begin
        if (hash_done) begin
          result_valid_next = 1'b1;
          found_next        = valid_hash;
          state_next        = S_IDLE;
          cnt_next          = '0;
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Registered outputs are derived from the next state so they line up with it.
  assign rx_ready_next     = (state_next == S_IDLE) || (state_next == S_FILL) ||
                             (state_next == S_DRAIN);
  assign header_valid_next = (state_next == S_HOLD);
  assign drop_err_next     = write_enable & ~rx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      byte_cnt     <= '0;
      rx_ready     <= 1'b1;
      header_valid <= 1'b0;
      result_valid <= 1'b0;
      result_found <= 1'b0;
      len_err      <= 1'b0;
      drop_err     <= 1'b0;
    end else begin
      state        <= state_next;
      byte_cnt     <= cnt_next;
      rx_ready     <= rx_ready_next;
      header_valid <= header_valid_next;
      result_valid <= result_valid_next;
      result_found <= found_next;
      len_err      <= len_err_next;
      drop_err     <= drop_err_next;
    end
  end

  // Byte i belongs to the beat whose base offset is i rounded down to a beat boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      header <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < HDR_BYTES; i++) begin
        if (byte_cnt == CNT_W'(i - (i % BEAT_BYTES))) begin
          header[8*i +: 8] <= rx_data[8*(i % BEAT_BYTES) +: 8];
        end
      end
    end
  end

  generate
    if (HDR_BYTES >= 76) begin : g_target
      assign target_bits = header[8*76-1 : 8*72];
    end else begin : g_no_target
      assign target_bits = 32'd0;
    end
  endgenerate

endmodule

// File: doc/pd_header_assembler.md
# pd_header_assembler

Parametrised successor to the packet decoder in the miner datapath. It sits between the UART/SPI receive front end and the SHA-256d hash engine. It assembles a fixed-length block header from a multi-byte-per-beat receive stream and checks the packet length. It then hands the header to the hash engine with a valid/ready handshake and reports the hash outcome as a one-cycle result pulse.

## Interface
Parameters:
- BEAT_BYTES, 1, bytes per receive beat. Legal values: 1, 2, 4.
- HDR_BYTES, 80, header length in bytes. Must be a multiple of BEAT_BYTES.
- CNT_W, $clog2(HDR_BYTES+1), byte counter width (localparam).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- write_enable  in  1  rx_data beat is valid this cycle.
- rx_data  in  8*BEAT_BYTES  receive beat; lane 0 (bits 7:0) is the earliest byte.
- rx_last  in  1  qualifies the final beat of a packet (only meaningful with write_enable).
- rx_ready  out  1  decoder is accepting beats.
- byte_cnt  out  CNT_W  bytes accepted in the current packet.
- header  out  8*HDR_BYTES  assembled header; byte i occupies bits 8i+7:8i.
- target_bits  out  32  header bytes 72..75, little-endian. Present only if HDR_BYTES ≥ 76; otherwise tied to 0.
- header_valid  out  1  header is complete and offered to the hash engine.
- header_ready  in  1  hash engine accepts the header.
- hash_done  in  1  hash engine has finished the accepted header (pulse).
- valid_hash  in  1  result qualifier, sampled together with hash_done.
- result_valid  out  1  one-cycle pulse: the hash outcome is available.
- result_found  out  1  value of valid_hash captured at hash_done. Held until the next result.
- len_err  out  1  one-cycle pulse: bad packet length.
- drop_err  out  1  one-cycle pulse: beat offered while rx_ready=0.

## Operation
States: IDLE, FILL, DRAIN, HOLD, HASH.
- IDLE: rx_ready=1, byte_cnt=0. An accepted beat writes header bytes 0..BEAT_BYTES-1 and moves to FILL. The transition rules below apply to this first beat as well.
- FILL: each accepted beat writes lanes at byte offsets byte_cnt..byte_cnt+BEAT_BYTES-1, then byte_cnt += BEAT_BYTES. Outcomes:
  - rx_last with new count == HDR_BYTES → HOLD.
  - rx_last with new count < HDR_BYTES → len_err pulse, → IDLE (short packet; header contents are don't-care).
  - new count == HDR_BYTES without rx_last → DRAIN.
- DRAIN: rx_ready=1. Beats are discarded and header is not written. The beat carrying rx_last → len_err pulse, → IDLE.
- HOLD: header_valid=1 and rx_ready=0. header and target_bits are stable. header_ready=1 → HASH.
- HASH: rx_ready=0, header stays stable. hash_done=1 → result_valid pulse, result_found←valid_hash, → IDLE.
- hash_done outside HASH is ignored. valid_hash without hash_done is ignored.
- write_enable while rx_ready=0 → beat dropped and drop_err pulses. The state machine is unaffected.
- byte_cnt returns to 0 on every entry to IDLE.
- byte_cnt saturates at HDR_BYTES; in DRAIN it does not increment.

## Timing
- Reset values: state IDLE; rx_ready=1; byte_cnt=0; header=0; target_bits=0; header_valid=0; result_valid=0; result_found=0; len_err=0; drop_err=0.
- Reset asserted mid-packet or mid-hash aborts immediately with no error pulses. rx_ready is 1 in the first cycle after release.
- All outputs are registered. A beat accepted at edge N is visible in header/byte_cnt after edge N.
- Latency:
  - Final-beat edge → header_valid=1 in the next cycle.
  - header_valid&header_ready edge → HASH. rx_ready stays 0 through HOLD and HASH.
  - hash_done edge → result_valid=1 for exactly the following cycle, with rx_ready=1 in that same cycle.
- Back-to-back packets: a beat may be accepted in the same cycle that result_valid is high.
- len_err, drop_err and result_valid are each high for exactly one cycle per event.

## Test plan
- BEAT_BYTES=1, HDR_BYTES=80: send bytes 0x00..0x4F with rx_last on byte 79, and hold header_ready=1 → header_valid rises the cycle after the last byte; header[7:0]=0x00, header[639:632]=0x4F; target_bits=0x4B4A4948.
- BEAT_BYTES=4: 20 beats, beat k = {4k+3,4k+2,4k+1,4k}, rx_last on beat 19; hold header_ready=0 for 5 cycles → header_valid stays 1 and header stays stable; byte_cnt=80; beats sent during HOLD produce drop_err pulses.
- Short packet: rx_last on byte 10 (BEAT_BYTES=1) → len_err pulses once, byte_cnt=0 next cycle, header_valid never rises.
- Long packet: 85 bytes with rx_last on byte 84 → DRAIN after byte 79, len_err on the byte-84 edge, header_valid never rises.
- Hash result: in HASH, pulse hash_done with valid_hash=1 → result_valid 1 cycle, result_found=1. Repeat with valid_hash=0 → result_found=0. A hash_done pulsed in IDLE produces nothing.
- Assert rst during FILL at byte 40 → all outputs return to reset values. Then a full 80-byte packet completes normally.
